imem_dmem_arbiter: RTL and testbench

//  Shares the core's single RAM port between the I$ fetch-miss path and the D$ load/store path.

---
 rtl/imem_dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single RAM port between I$ fetch misses and D$ loads/stores.
// Define ARB_STARVE_GUARD_EN to bound how long D$ traffic can starve an I$ request.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOG_STARVE   = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_load,
  input  logic        d_REN,
  input  logic        d_WEN,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_store,
  output logic        d_done,
  output logic [31:0] d_load,
  output logic        ram_REN,
  output logic        ram_WEN,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic        ram_ready,
  input  logic [31:0] ram_load,
  output logic        arb_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  if (2 ** LOG_STARVE <= STARVE_LIMIT) begin : g_bad_params
    $error("LOG_STARVE too narrow to hold STARVE_LIMIT");
  end

  logic [1:0] state_q, state_d;
  logic       arb_error_q;
  logic       d_req;
  logic       i_first;

  assign d_req = d_REN | d_WEN;

`ifdef ARB_STARVE_GUARD_EN
  logic [LOG_STARVE-1:0] cnt_q, cnt_d;

  assign i_first = i_req && (cnt_q >= LOG_STARVE'(STARVE_LIMIT));

  // Count only D$ grants that actually made a waiting I$ request wait.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == SERVE_I)
      cnt_d = '0;
    else if (state_q == IDLE && state_d == SERVE_D && i_req &&
             cnt_q < LOG_STARVE'(STARVE_LIMIT))
      cnt_d = cnt_q + LOG_STARVE'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign i_first = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_first)    state_d = SERVE_I;
        else if (d_req) state_d = SERVE_D;
        else if (i_req) state_d = SERVE_I;
      end
      SERVE_I: if (!i_req || ram_ready) state_d = IDLE;
      SERVE_D: if (!d_req || ram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by nRST so a mid-access reset silences the port immediately.
  always_comb begin
    i_done    = 1'b0;
    i_load    = '0;
    d_done    = 1'b0;
    d_load    = '0;
    ram_REN   = 1'b0;
    ram_WEN   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    if (nRST) begin
      case (state_q)
        SERVE_I: begin
          ram_REN  = i_req;
          ram_addr = i_addr;
          i_done   = i_req & ram_ready;
          if (i_done) i_load = ram_load;
        end
        SERVE_D: begin
          ram_REN   = d_REN & ~d_WEN;
          ram_WEN   = d_WEN;
          ram_addr  = d_addr;
          ram_store = d_store;
          d_done    = d_req & ram_ready;
          if (d_done && !d_WEN) d_load = ram_load;
        end
        default: ;
      endcase
    end
  end

  assign arb_error = arb_error_q & nRST;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      arb_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arb_error_q <= arb_error_q | (d_REN & d_WEN);
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter; done pulses are checked against a scoreboard queue.
module tb_imem_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_load;
  logic        d_REN, d_WEN;
  logic [31:0] d_addr, d_store;
  logic        d_done;
  logic [31:0] d_load;
  logic        ram_REN, ram_WEN;
  logic [31:0] ram_addr, ram_store;
  logic        ram_ready;
  logic [31:0] ram_load;
  logic        arb_error;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  imem_dmem_arbiter #(.STARVE_LIMIT(4), .LOG_STARVE(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_load(i_load),
    .d_REN(d_REN), .d_WEN(d_WEN), .d_addr(d_addr), .d_store(d_store),
    .d_done(d_done), .d_load(d_load),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_ready(ram_ready), .ram_load(ram_load), .arb_error(arb_error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_done(input logic is_d, input logic [31:0] load);
    exp_t e;
    e.is_d = is_d;
    e.load = load;
    sb.push_back(e);
  endtask

  task automatic chk_quiet(input string name);
    #1;
    chk({name, "_ren"},   {31'b0, ram_REN}, 32'd0);
    chk({name, "_wen"},   {31'b0, ram_WEN}, 32'd0);
    chk({name, "_addr"},  ram_addr, 32'd0);
    chk({name, "_store"}, ram_store, 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (i_done || d_done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got i_done=%b d_done=%b expected none at %0t",
                 i_done, d_done, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dual_done", {31'b0, i_done & d_done}, 32'd0);
        chk("done_port_is_d", {31'b0, d_done}, {31'b0, e.is_d});
        chk("done_load", d_done ? d_load : i_load, e.load);
        chk("other_load", d_done ? i_load : d_load, 32'd0);
      end
    end else if (nRST) begin
      chk("idle_loads_zero", i_load | d_load, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; i_req = 1'b0; i_addr = '0; d_REN = 1'b0; d_WEN = 1'b0;
    d_addr = '0; d_store = '0; ram_ready = 1'b0; ram_load = '0;
    tick(); tick();
    d_REN = 1'b1; d_addr = 32'h10;
    chk_quiet("reset");
    chk("reset_err", {31'b0, arb_error}, 32'd0);
    chk("reset_done", {30'b0, i_done, d_done}, 32'd0);
    tick();
    d_REN = 1'b0; d_addr = '0;

    // 1: I$ fetch, RAM ready on the cycle after the grant
    nRST = 1'b1; i_req = 1'b1; i_addr = 32'h40; ram_load = 32'hDEADBEEF;
    chk_quiet("t1_req_cycle");
    tick();
    #1;
    chk("t1_ren", {31'b0, ram_REN}, 32'd1);
    chk("t1_wen", {31'b0, ram_WEN}, 32'd0);
    chk("t1_addr", ram_addr, 32'h40);
    chk("t1_store", ram_store, 32'd0);
    tick();
    ram_ready = 1'b1; expect_done(1'b0, 32'hDEADBEEF);
    tick();
    i_req = 1'b0; ram_ready = 1'b0;
    chk_quiet("t1_after");

    // 2: simultaneous requests, D$ wins, one IDLE gap, then I$
    tick();
    i_req = 1'b1; i_addr = 32'h44; d_REN = 1'b1; d_addr = 32'h80;
    tick();
    ram_ready = 1'b1; ram_load = 32'hA5A5A5A5; expect_done(1'b1, 32'hA5A5A5A5);
    #1;
    chk("t2_d_ren", {31'b0, ram_REN}, 32'd1);
    chk("t2_d_addr", ram_addr, 32'h80);
    tick();
    d_REN = 1'b0; ram_load = 32'h0BADF00D;
    chk_quiet("t2_gap");
    tick();
    expect_done(1'b0, 32'h0BADF00D);
    #1;
    chk("t2_i_ren", {31'b0, ram_REN}, 32'd1);
    chk("t2_i_addr", ram_addr, 32'h44);
    tick();
    i_req = 1'b0; ram_ready = 1'b0;

    // 3: D$ write completing right after the grant
    tick();
    d_WEN = 1'b1; d_addr = 32'h100; d_store = 32'h12345678; ram_load = 32'hFFFFFFFF;
    tick();
    ram_ready = 1'b1; expect_done(1'b1, 32'h0);
    #1;
    chk("t3_wen", {31'b0, ram_WEN}, 32'd1);
    chk("t3_ren", {31'b0, ram_REN}, 32'd0);
    chk("t3_store", ram_store, 32'h12345678);
    chk("t3_addr", ram_addr, 32'h100);
    tick();
    d_WEN = 1'b0; d_store = '0; d_addr = '0; ram_ready = 1'b0;

    // 4: I$ abort before ram_ready; ready arriving in the abort cycle must be ignored
    tick();
    i_req = 1'b1; i_addr = 32'h200;
    tick();
    #1;
    chk("t4_granted_ren", {31'b0, ram_REN}, 32'd1);
    i_req = 1'b0; ram_ready = 1'b1;
    #1;
    chk("t4_abort_ren", {31'b0, ram_REN}, 32'd0);
    tick();
    i_req = 1'b1; ram_ready = 1'b0;
    chk_quiet("t4_idle_after_abort");
    tick();
    ram_ready = 1'b1; ram_load = 32'h00C0FFEE; expect_done(1'b0, 32'h00C0FFEE);
    tick();
    i_req = 1'b0; ram_ready = 1'b0;

    // 5: continuous D$ reads with I$ waiting; five grants observed
    tick();
    i_req = 1'b1; i_addr = 32'h300; d_REN = 1'b1; d_addr = 32'h400;
    ram_ready = 1'b1; ram_load = 32'h55;
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      expect_done(k != 4, 32'h55);
`else
      expect_done(1'b1, 32'h55);
`endif
    end
    repeat (10) tick();
    i_req = 1'b0; d_REN = 1'b0; ram_ready = 1'b0;
    chk("t5_all_served", sb.size(), 32'd0);

    // 6: reset mid SERVE_D, then an illegal read+write request
    tick();
    d_REN = 1'b1; d_addr = 32'h500;
    tick();
    #1;
    chk("t6_serving", {31'b0, ram_REN}, 32'd1);
    nRST = 1'b0;
    chk_quiet("t6_in_reset");
    tick();
    nRST = 1'b1; d_WEN = 1'b1; d_store = 32'hCAFEF00D;
    chk_quiet("t6_idle_after_reset");
    chk("t6_err_clear", {31'b0, arb_error}, 32'd0);
    tick();
    #1;
    chk("t6_err_set", {31'b0, arb_error}, 32'd1);
    chk("t6_as_write_wen", {31'b0, ram_WEN}, 32'd1);
    chk("t6_as_write_ren", {31'b0, ram_REN}, 32'd0);
    d_REN = 1'b0; d_WEN = 1'b0;
    tick();
    d_store = '0; d_addr = '0;
    chk("t6_err_sticky", {31'b0, arb_error}, 32'd1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    chk("t6_err_reset", {31'b0, arb_error}, 32'd0);

    tick(); tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
